// File: rtl/wb_dmem_arbiter_pkg.sv
// Shared SoC definitions for the data-memory Wishbone arbiter:
// arbiter state encoding and the grant indication codes.
package wb_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GNT_M0 = 2'b01,
        ST_GNT_M1 = 2'b10,
        ST_ABORT  = 2'b11
    } arb_state_e;

    localparam logic [1:0] GRANT_IDLE  = 2'b00;
    localparam logic [1:0] GRANT_M0    = 2'b01;
    localparam logic [1:0] GRANT_M1    = 2'b10;
    localparam logic [1:0] GRANT_ABORT = 2'b11;

    localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/wb_dmem_arbiter_timeout_cnt.sv
// Slave-response watchdog: counts unanswered strobe cycles and flags the
// cycle in which the allowed budget runs out.
module wb_timeout_cnt
    import wb_dmem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic tc_o
);

    localparam logic [TMO_CNT_W-1:0] TC_VAL = TMO_CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TMO_CNT_W-1:0] cnt_r;

    // Counter register; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Terminal count only in a strobed cycle that got no response.
    assign tc_o = inc & (cnt_r == TC_VAL);

endmodule

// File: rtl/wb_dmem_arbiter.sv
// Two-master to one-slave Wishbone arbiter for the data memory with locked
// cycles, round-robin or fixed priority, and a slave-response timeout.
module wb_dmem_arbiter
    import wb_dmem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RR_ENABLE      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    arb_state_e state_r, state_s;
    logic       last_m1_r, last_m1_s;
    logic       granted_s, gnt_stb_s, tc_s;

    // The strobe feeding the watchdog is taken from the masters directly so
    // the timeout path never loops back through the slave-side mux.
    assign granted_s = (state_r == ST_GNT_M0) | (state_r == ST_GNT_M1);
    assign gnt_stb_s = ((state_r == ST_GNT_M0) & m0_stb_i) | ((state_r == ST_GNT_M1) & m1_stb_i);

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (~granted_s | s_ack_i | s_err_i),
        .inc     (gnt_stb_s & ~s_ack_i & ~s_err_i),
        .tc_o    (tc_s)
    );

    // State and last-grant registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            last_m1_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            last_m1_r <= last_m1_s;
        end
    end

    // Next-state logic: arbitration, locked-cycle hold, timeout abort.
    always_comb begin
        state_s   = state_r;
        last_m1_s = last_m1_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (RR_ENABLE && !last_m1_r) begin
                        state_s   = ST_GNT_M1;
                        last_m1_s = 1'b1;
                    end else begin
                        state_s   = ST_GNT_M0;
                        last_m1_s = 1'b0;
                    end
                end else if (m0_cyc_i) begin
                    state_s   = ST_GNT_M0;
                    last_m1_s = 1'b0;
                end else if (m1_cyc_i) begin
                    state_s   = ST_GNT_M1;
                    last_m1_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GNT_M0: begin
                if (!m0_cyc_i)  state_s = ST_IDLE;
                else if (tc_s)  state_s = ST_ABORT;
                else            state_s = ST_GNT_M0;
            end
            ST_GNT_M1: begin
                if (!m1_cyc_i)  state_s = ST_IDLE;
                else if (tc_s)  state_s = ST_ABORT;
                else            state_s = ST_GNT_M1;
            end
            ST_ABORT: begin
                // last_grant still names the aborted master here.
                if (last_m1_r ? !m1_cyc_i : !m0_cyc_i) state_s = ST_IDLE;
                else                                    state_s = ST_ABORT;
            end
            default: begin
                state_s   = ST_IDLE;
                last_m1_s = 1'b1;
            end
        endcase
    end

    // Bus steering: granted master to slave, slave response to that master only.
    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (state_r == ST_GNT_M0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i & ~s_err_i;
            m0_err_o = s_err_i | tc_s;
        end else if (state_r == ST_GNT_M1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i & ~s_err_i;
            m1_err_o = s_err_i | tc_s;
        end else begin
            s_cyc_o = 1'b0;
        end
    end

    // Grant indication decoded from the state register.
    always_comb begin
        case (state_r)
            ST_IDLE:   grant_o = GRANT_IDLE;
            ST_GNT_M0: grant_o = GRANT_M0;
            ST_GNT_M1: grant_o = GRANT_M1;
            ST_ABORT:  grant_o = GRANT_ABORT;
            default:   grant_o = GRANT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// Self-checking bench for wb_dmem_arbiter: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_wb_dmem_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] m0_adr_i = 32'd0, m0_dat_i = 32'd0, m1_adr_i = 32'd0, m1_dat_i = 32'd0;
    logic [3:0]  m0_sel_i = 4'd0, m1_sel_i = 4'd0;
    logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
    logic [31:0] s_dat_i = 32'd0;
    logic        s_ack_i = 1'b0, s_err_i = 1'b0;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    logic [31:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_adr_o, fp_s_dat_o;
    logic        fp_m0_ack_o, fp_m0_err_o, fp_m1_ack_o, fp_m1_err_o, fp_s_we_o, fp_s_cyc_o, fp_s_stb_o;
    logic [3:0]  fp_s_sel_o;
    logic [1:0]  fp_grant_o;

    wb_dmem_arbiter #(.TIMEOUT_CYCLES(TMO), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    wb_dmem_arbiter #(.TIMEOUT_CYCLES(TMO), .RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(fp_m0_dat_o), .m0_ack_o(fp_m0_ack_o), .m0_err_o(fp_m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(fp_m1_dat_o), .m1_ack_o(fp_m1_ack_o), .m1_err_o(fp_m1_err_o),
        .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_sel_o(fp_s_sel_o), .s_we_o(fp_s_we_o), .s_cyc_o(fp_s_cyc_o),
        .s_stb_o(fp_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(fp_grant_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the bus (0 none, 1 m0, 2 m1, 3 aborted),
    // who won last, and how many strobed cycles went unanswered.
    int own      = 0;
    int last_won = 1;
    int waited   = 0;
    int aborted  = 0;
    bit rnd_fields = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        own = 0; last_won = 1; waited = 0; aborted = 0;
    endtask

    task automatic check_cycle();
        int          who, pick;
        logic        g_cyc, g_stb, g_we, tmo;
        logic [31:0] g_adr, g_dat;
        logic [3:0]  g_sel;
        who = (own == 1) ? 0 : ((own == 2) ? 1 : -1);
        g_cyc = 1'b0; g_stb = 1'b0; g_we = 1'b0; g_adr = 32'd0; g_dat = 32'd0; g_sel = 4'd0;
        if (who == 0) begin
            g_cyc = m0_cyc_i; g_stb = m0_stb_i; g_we = m0_we_i; g_adr = m0_adr_i; g_dat = m0_dat_i; g_sel = m0_sel_i;
        end else if (who == 1) begin
            g_cyc = m1_cyc_i; g_stb = m1_stb_i; g_we = m1_we_i; g_adr = m1_adr_i; g_dat = m1_dat_i; g_sel = m1_sel_i;
        end
        tmo = (who >= 0) && g_stb && !s_ack_i && !s_err_i && (waited == TMO - 1);
        check_val("grant", {30'd0, grant_o}, own);
        check_val("s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, {29'd0, g_cyc, g_stb, g_we});
        check_val("s_adr", s_adr_o, g_adr);
        check_val("s_dat", s_dat_o, g_dat);
        check_val("s_sel", {28'd0, s_sel_o}, {28'd0, g_sel});
        check_val("m0_resp", {30'd0, m0_ack_o, m0_err_o},
                  {30'd0, (who == 0) && s_ack_i && !s_err_i, (who == 0) && (s_err_i || tmo)});
        check_val("m1_resp", {30'd0, m1_ack_o, m1_err_o},
                  {30'd0, (who == 1) && s_ack_i && !s_err_i, (who == 1) && (s_err_i || tmo)});
        check_val("m0_dat", m0_dat_o, (who == 0) ? s_dat_i : 32'd0);
        check_val("m1_dat", m1_dat_o, (who == 1) ? s_dat_i : 32'd0);
        // advance the model across the coming clock edge
        if (s_ack_i || s_err_i) waited = 0;
        else if ((who >= 0) && g_stb) waited++;
        case (own)
            0: begin
                if (m0_cyc_i && m1_cyc_i) pick = 1 - last_won;
                else if (m0_cyc_i)        pick = 0;
                else if (m1_cyc_i)        pick = 1;
                else                      pick = -1;
                if (pick >= 0) begin own = pick + 1; last_won = pick; end
            end
            1, 2: begin
                if (!g_cyc)   own = 0;
                else if (tmo) begin own = 3; aborted = who; end
            end
            3: if ((aborted == 0) ? !m0_cyc_i : !m1_cyc_i) own = 0;
            default: own = 0;
        endcase
        if (own == 0 || own == 3) waited = 0;
    endtask

    task automatic cycle(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic ak, input logic er, input logic [31:0] sd);
        @(posedge clk);
        #2;
        m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1;
        s_ack_i = ak; s_err_i = er; s_dat_i = sd;
        if (rnd_fields) begin
            m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
            m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
        end
        #1;
        check_cycle();
    endtask

    task automatic full_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic c0, c1, quiet;
        int   err_at, err_cnt;
        model_reset();
        #3;
        check_val("rst_grant", {30'd0, grant_o}, 32'd0);
        check_val("rst_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
        check_val("rst_resp", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // single m0 read, slave answers on the third granted cycle
        m0_adr_i = 32'h0000_0100; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("rd_idle_grant", {30'd0, grant_o}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check_val("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        check_val("rd_ack", {31'd0, m0_ack_o}, 32'd1);
        check_val("rd_m1_quiet", {m1_dat_o[31:2], m1_ack_o | m1_dat_o[1], m1_err_o | m1_dat_o[0]}, 32'd0);
        check_val("rd_grant", {30'd0, grant_o}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("rd_end_grant", {30'd0, grant_o}, 32'd0);

        // simultaneous requests: alternate under round-robin, m0 under fixed priority
        full_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
            check_val("tie_rr", {30'd0, grant_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check_val("tie_fp", {30'd0, fp_grant_o}, 32'd1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // m1 locked for four beats while m0 waits
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int b = 0; b < 4; b++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, $urandom);
            check_val("lock_grant", {30'd0, grant_o}, 32'd2);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("lock_fall", {30'd0, grant_o}, 32'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("lock_gap", {30'd0, grant_o}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("lock_m0", {30'd0, grant_o}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // silent slave: err on the eighth strobe cycle, then abort
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        err_at = 0; err_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            if (m0_err_o) begin err_at = i; err_cnt++; end
        end
        check_val("tmo_err_cycle", err_at, 32'd8);
        check_val("tmo_err_pulses", err_cnt, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        check_val("tmo_abort", {30'd0, grant_o}, 32'd3);
        check_val("tmo_late_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("tmo_hold", {30'd0, grant_o}, 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("tmo_exit", {30'd0, grant_o}, 32'd0);

        // reset in the middle of an m1 write
        m1_we_i = 1'b1; m1_adr_i = 32'h0000_0040; m1_dat_i = 32'hCAFE_F00D; m1_sel_i = 4'h3;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        check_val("wr_s_cyc", {31'd0, s_cyc_o}, 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0; s_ack_i = 1'b1;
        #1;
        check_val("mid_rst_s_ctl", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        check_val("mid_rst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        check_val("mid_rst_grant", {30'd0, grant_o}, 32'd0);
        model_reset();
        @(negedge clk);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; reset_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE);
        check_val("post_rst_m0", {m0_dat_o[31:1], m0_ack_o}, {31'h05D6_E57F, 1'b1});
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // ack+err together means err; ack in terminal-count cycle beats timeout
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        check_val("ack_err_both", {30'd0, m0_ack_o, m0_err_o}, 32'd1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA);
        check_val("tc_ack_wins", {30'd0, m0_ack_o, m0_err_o}, 32'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_val("tc_ack_stay", {30'd0, grant_o}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // random traffic with occasional silent-slave stretches
        rnd_fields = 1'b1;
        c0 = 1'b0; c1 = 1'b0; quiet = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0)  c0 = ~c0;
            if ($urandom_range(0, 5) == 0)  c1 = ~c1;
            if ($urandom_range(0, 39) == 0) quiet = ~quiet;
            cycle(c0, c0 & ($urandom_range(0, 3) != 0), c1, c1 & ($urandom_range(0, 3) != 0),
                  !quiet && ($urandom_range(0, 2) == 0), !quiet && ($urandom_range(0, 15) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
